// File: rtl/alu_op_pkg.sv
// Shared opcode constants, sequencer state encoding and chord decode for the
// button-driven ALU op sequencer.
package alu_op_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_PEND     = 2'd2,
        ST_WAIT_REL = 2'd3
    } seq_state_t;

    // Chord is {left, centre, right}; the empty chord never reaches decode.
    function automatic logic [3:0] chord_to_op(input logic [2:0] chord);
        logic [3:0] op;
        op = ALU_ADD;
        case (chord)
            3'b001:  op = ALU_SUB;
            3'b010:  op = ALU_AND;
            3'b011:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SLT;
            3'b110:  op = ALU_SLL;
            3'b111:  op = ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: two-flop synchroniser followed by a stable-count debouncer
// whose registered level flips after DB_CYCLES consecutive disagreeing cycles.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 != level) begin
                // The edge that sees the DB_CYCLES-th disagreeing cycle flips the level.
                if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_alu_op_sequencer.sv
// Debounces three buttons, accumulates the pressed chord until full release,
// then offers the decoded ALU opcode once over a valid/ready handshake.
module btn_alu_op_sequencer
    import alu_op_pkg::*;
#(
    parameter int unsigned          DB_CYCLES = 500000,
    parameter int unsigned          ALU_OP_W  = 4,
    parameter logic [ALU_OP_W-1:0]  RST_OP    = ALU_OP_W'(4'b0010)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                btnl,
    input  logic                btnc,
    input  logic                btnr,
    input  logic                op_ready,
    output logic                op_valid,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                busy
);

    logic       lvl_l;
    logic       lvl_c;
    logic       lvl_r;
    logic [2:0] lvl;
    logic [2:0] chord;
    seq_state_t state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (
        .clk    (clk),
        .resetn (resetn),
        .btn    (btnl),
        .level  (lvl_l)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (
        .clk    (clk),
        .resetn (resetn),
        .btn    (btnc),
        .level  (lvl_c)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk    (clk),
        .resetn (resetn),
        .btn    (btnr),
        .level  (lvl_r)
    );

    assign lvl = {lvl_l, lvl_c, lvl_r};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            chord    <= '0;
            alu_op   <= RST_OP;
            op_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|lvl) begin
                        state <= ST_COLLECT;
                        chord <= lvl;
                        busy  <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    chord <= chord | lvl;
                    if (lvl == 3'b000) begin
                        state    <= ST_PEND;
                        alu_op   <= (chord == 3'b000) ? RST_OP
                                                      : ALU_OP_W'(chord_to_op(chord));
                        op_valid <= 1'b1;
                    end
                end
                // Presses seen here are not chorded; they only gate the exit path.
                ST_PEND: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        if (|lvl) begin
                            state <= ST_WAIT_REL;
                        end else begin
                            state <= ST_IDLE;
                            chord <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (lvl == 3'b000) begin
                        state <= ST_IDLE;
                        chord <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    chord    <= '0;
                    op_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_alu_op_sequencer.sv
// Directed bench for btn_alu_op_sequencer with a short debounce window.
module tb_btn_alu_op_sequencer;

    localparam int unsigned DB  = 4;
    localparam int          LAT = 2 + DB + 1;

    logic       clk = 1'b0;
    logic       resetn;
    logic       btnl;
    logic       btnc;
    logic       btnr;
    logic       op_ready;
    logic       op_valid;
    logic [3:0] alu_op;
    logic       busy;

    int total    = 0;
    int passed   = 0;
    int spurious = 0;

    typedef struct {
        string      name;
        logic [2:0] chord;
        logic [3:0] op;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    btn_alu_op_sequencer #(
        .DB_CYCLES (DB),
        .ALU_OP_W  (4),
        .RST_OP    (4'b0010)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .btnl     (btnl),
        .btnc     (btnc),
        .btnr     (btnr),
        .op_ready (op_ready),
        .op_valid (op_valid),
        .alu_op   (alu_op),
        .busy     (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance n cycles, counting any op_valid seen as spurious.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (op_valid) spurious++;
        end
    endtask

    task automatic check_quiet(input string name);
        check(name, spurious, 0);
        spurious = 0;
    endtask

    // Called right after the final raw release; expects exactly one op.
    task automatic monitor_op(input string name, input logic [3:0] exp_op, input int exp_lat);
        int   first;
        int   pulses;
        logic prev;
        logic [3:0] seen;
        first  = -1;
        pulses = 0;
        prev   = 1'b0;
        seen   = 4'hx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (op_valid && !prev) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    seen  = alu_op;
                end
            end
            prev = op_valid;
        end
        if (exp_lat > 0) check({name, " latency"}, first, exp_lat);
        check({name, " alu_op"}, int'(seen), int'(exp_op));
        check({name, " pulses"}, pulses, 1);
        check({name, " busy after"}, int'(busy), 0);
        check({name, " alu_op held"}, int'(alu_op), int'(exp_op));
    endtask

    initial begin
        int bad;

        vecs[0] = '{"chord_c",   3'b010, 4'b0000};
        vecs[1] = '{"chord_r",   3'b001, 4'b0110};
        vecs[2] = '{"chord_cr",  3'b011, 4'b0001};
        vecs[3] = '{"chord_l",   3'b100, 4'b1101};
        vecs[4] = '{"chord_lr",  3'b101, 4'b0111};
        vecs[5] = '{"chord_lc",  3'b110, 4'b1001};
        vecs[6] = '{"chord_lcr", 3'b111, 4'b1010};

        resetn   = 1'b0;
        btnl     = 1'b0;
        btnc     = 1'b0;
        btnr     = 1'b0;
        op_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset alu_op", int'(alu_op), 'h2);
        check("reset op_valid", int'(op_valid), 0);
        check("reset busy", int'(busy), 0);

        // Clean presses of every chord, op_ready held high
        for (int v = 0; v < 7; v++) begin
            {btnl, btnc, btnr} = vecs[v].chord;
            hold(20);
            check_quiet({vecs[v].name, " no early op"});
            check({vecs[v].name, " busy held"}, int'(busy), 1);
            {btnl, btnc, btnr} = 3'b000;
            monitor_op(vecs[v].name, vecs[v].op, LAT);
            hold(3);
        end

        // Bounce on btnr never reaches the debounced level
        bad  = 0;
        btnr = 1'b1; @(negedge clk); if (busy) bad++;
        btnr = 1'b0; @(negedge clk); if (busy) bad++;
        btnr = 1'b1;
        for (int i = 0; i < 2 + DB; i++) begin
            @(negedge clk);
            if (busy) bad++;
        end
        check("bounce busy low", bad, 0);
        @(negedge clk);
        check("bounce busy rises", int'(busy), 1);
        hold(13);
        check_quiet("bounce no early op");
        btnr = 1'b0;
        monitor_op("bounce", 4'b0110, LAT);

        // Staggered press and release merges into one chord
        btnl = 1'b1;
        hold(10);
        btnr = 1'b1;
        hold(10);
        btnl = 1'b0;
        hold(10);
        check_quiet("stagger no early op");
        btnr = 1'b0;
        monitor_op("stagger", 4'b0111, LAT);

        // Back-pressure: op held while op_ready low, presses during PEND ignored
        op_ready = 1'b0;
        {btnl, btnc, btnr} = 3'b111;
        hold(20);
        check_quiet("pend no early op");
        {btnl, btnc, btnr} = 3'b000;
        repeat (LAT) @(negedge clk);
        check("pend valid", int'(op_valid), 1);
        check("pend alu_op", int'(alu_op), 'ha);
        btnc = 1'b1;
        bad  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!op_valid || alu_op != 4'b1010) bad++;
        end
        check("pend held stable", bad, 0);
        op_ready = 1'b1;
        @(negedge clk);
        check("pend valid drops", int'(op_valid), 0);
        check("wait_rel busy", int'(busy), 1);
        hold(20);
        check_quiet("wait_rel no second op");
        btnc = 1'b0;
        hold(20);
        check_quiet("after release no op");
        check("wait_rel exits", int'(busy), 0);
        check("wait_rel alu_op kept", int'(alu_op), 'ha);

        // Reset mid-chord discards the pending op
        btnl = 1'b1;
        hold(20);
        check("collect busy", int'(busy), 1);
        resetn = 1'b0;
        hold(2);
        resetn = 1'b1;
        check_quiet("reset mid-chord no op");
        check("reset mid-chord alu_op", int'(alu_op), 'h2);
        check("reset mid-chord busy", int'(busy), 0);
        hold(15);
        check("rechord busy", int'(busy), 1);
        check_quiet("rechord no early op");
        btnl = 1'b0;
        monitor_op("rechord", 4'b1101, LAT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
